// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: sequential word fetches over a req/ack ROM bus,
// buffered as {pc, inst} pairs and handed to If2Id with valid/ready; flush redirects.
module inst_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic        rom_ack_i,
  input  logic [31:0] rom_data_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  input  logic        inst_ready_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_mem_inst [DEPTH];
  logic [31:0]   r_mem_pc   [DEPTH];

  logic          w_push;
  logic          w_pop;
  logic          w_room;
  logic [CW-1:0] w_count_next;
  logic [AW-1:0] w_rd_next;
  logic [AW-1:0] w_wr_next;
  logic [31:0]   w_flush_pc;
  logic [31:0]   w_pc_inc;
  logic [31:0]   w_head_inst;
  logic [31:0]   w_head_pc;

  // FIFO bookkeeping and next head entry; a push into an emptying FIFO bypasses storage
  always_comb begin
    w_push       = (r_state == S_REQ) && rom_ack_i && !flush_i;
    w_pop        = inst_valid_o && inst_ready_i && !flush_i;
    w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    w_rd_next    = r_rd_ptr + AW'(w_pop);
    w_wr_next    = r_wr_ptr + AW'(w_push);
    w_room       = w_count_next < CW'(DEPTH);
    w_flush_pc   = flush_pc_i & ~32'h3;
    w_pc_inc     = r_fetch_pc + 32'd4;
    w_head_inst  = r_mem_inst[w_rd_next];
    w_head_pc    = r_mem_pc[w_rd_next];
    if (w_push && (r_wr_ptr == w_rd_next)) begin
      w_head_inst = rom_data_i;
      w_head_pc   = r_fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_inst[r_wr_ptr] <= rom_data_i;
      r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_fetch_pc   <= RESET_PC;
      rom_req_o    <= 1'b0;
      rom_addr_o   <= RESET_PC;
      inst_valid_o <= 1'b0;
      inst_o       <= '0;
      pc_o         <= '0;
    end else if (flush_i) begin
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_fetch_pc   <= w_flush_pc;
      inst_valid_o <= 1'b0;
      inst_o       <= '0;
      pc_o         <= '0;
      // An un-acked request must complete at its old address before redirecting
      case (r_state)
        S_REQ, S_DRAIN: begin
          rom_req_o <= 1'b1;
          if (rom_ack_i) begin
            r_state    <= S_REQ;
            rom_addr_o <= w_flush_pc;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        default: begin
          r_state    <= S_REQ;
          rom_req_o  <= 1'b1;
          rom_addr_o <= w_flush_pc;
        end
      endcase
    end else begin
      r_count      <= w_count_next;
      r_rd_ptr     <= w_rd_next;
      r_wr_ptr     <= w_wr_next;
      inst_valid_o <= (w_count_next != '0);
      inst_o       <= (w_count_next != '0) ? w_head_inst : 32'd0;
      pc_o         <= (w_count_next != '0) ? w_head_pc : 32'd0;
      case (r_state)
        S_IDLE: begin
          if (w_room) begin
            r_state    <= S_REQ;
            rom_req_o  <= 1'b1;
            rom_addr_o <= r_fetch_pc;
          end
        end
        S_REQ: begin
          if (rom_ack_i) begin
            r_fetch_pc <= w_pc_inc;
            rom_addr_o <= w_pc_inc;
            r_state    <= w_room ? S_REQ : S_IDLE;
            rom_req_o  <= w_room;
          end
        end
        S_DRAIN: begin
          if (rom_ack_i) begin
            r_state    <= S_REQ;
            rom_req_o  <= 1'b1;
            rom_addr_o <= r_fetch_pc;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          rom_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue: streaming, back-pressure, wait states,
// flush/drain, flush+ack collision, address wrap and mid-request reset.
module tb_inst_prefetch_queue;

  localparam logic [31:0] BASE = 32'h1c000000;

  logic        clk;
  logic        rst;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_ack_i;
  logic [31:0] rom_data_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        inst_ready_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  inst_prefetch_queue #(.DEPTH(4), .RESET_PC(BASE)) dut (
    .clk         (clk),
    .rst         (rst),
    .rom_req_o   (rom_req_o),
    .rom_addr_o  (rom_addr_o),
    .rom_ack_i   (rom_ack_i),
    .rom_data_i  (rom_data_i),
    .inst_valid_o(inst_valid_o),
    .inst_o      (inst_o),
    .pc_o        (pc_o),
    .inst_ready_i(inst_ready_i),
    .flush_i     (flush_i),
    .flush_pc_i  (flush_pc_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // ROM content is a fixed function of the address it is asked for
  always_comb rom_data_i = dat(rom_addr_o);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; inst_ready_i = 1'b0; rom_ack_i = 1'b0; flush_i = 1'b0; flush_pc_i = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  logic [31:0] wrap_pc [4];

  initial begin
    wrap_pc = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};

    // reset values
    do_reset();
    rst = 1'b1;
    chk("rst_req",   32'(rom_req_o),    32'd0);
    chk("rst_addr",  rom_addr_o,        BASE);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_inst",  inst_o,            32'd0);
    chk("rst_pc",    pc_o,              32'd0);

    // 1: zero-wait ROM, consumer always ready
    rst = 1'b0; inst_ready_i = 1'b1; rom_ack_i = 1'b1;
    chk("t1_req_first_cycle", 32'(rom_req_o), 32'd0);
    tick();
    chk("t1_req",  32'(rom_req_o), 32'd1);
    chk("t1_addr0", rom_addr_o, BASE);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1_valid", 32'(inst_valid_o), 32'd1);
      chk("t1_pc",    pc_o,   BASE + 32'(4 * i));
      chk("t1_inst",  inst_o, dat(BASE + 32'(4 * i)));
      chk("t1_addr",  rom_addr_o, BASE + 32'(4 * (i + 1)));
    end

    // 2: back-pressure fills exactly DEPTH entries
    do_reset();
    rom_ack_i = 1'b1;
    tick();
    chk("t2_addr0", rom_addr_o, BASE);
    tick(); tick(); tick(); tick();
    chk("t2_full_req",  32'(rom_req_o),    32'd0);
    chk("t2_full_valid", 32'(inst_valid_o), 32'd1);
    chk("t2_head_pc",   pc_o,   BASE);
    chk("t2_head_inst", inst_o, dat(BASE));
    tick();
    chk("t2_no_fifth_req", 32'(rom_req_o), 32'd0);
    chk("t2_idle_addr", rom_addr_o, BASE + 32'h10);
    inst_ready_i = 1'b1;
    tick();
    inst_ready_i = 1'b0;
    chk("t2_refill_req",  32'(rom_req_o), 32'd1);
    chk("t2_refill_addr", rom_addr_o, BASE + 32'h10);
    chk("t2_pop_pc",      pc_o, BASE + 32'h4);
    tick();
    chk("t2_refull_req", 32'(rom_req_o), 32'd0);
    tick();
    chk("t2_hold_req", 32'(rom_req_o), 32'd0);
    chk("t2_hold_pc",  pc_o, BASE + 32'h4);

    // 3: three wait states
    do_reset();
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t3_wait_req",   32'(rom_req_o), 32'd1);
      chk("t3_wait_addr",  rom_addr_o, BASE);
      chk("t3_wait_valid", 32'(inst_valid_o), 32'd0);
      tick();
    end
    rom_ack_i = 1'b1;
    chk("t3_ack_addr", rom_addr_o, BASE);
    tick();
    rom_ack_i = 1'b0;
    chk("t3_valid", 32'(inst_valid_o), 32'd1);
    chk("t3_pc",    pc_o,   BASE);
    chk("t3_inst",  inst_o, dat(BASE));
    chk("t3_next_addr", rom_addr_o, BASE + 32'h4);
    tick();
    chk("t3_single_push_pc", pc_o, BASE);

    // 4: flush while a request waits, 2 entries buffered
    do_reset();
    rom_ack_i = 1'b1;
    tick(); tick(); tick();
    rom_ack_i = 1'b0;
    chk("t4_pending_addr", rom_addr_o, BASE + 32'h8);
    tick();
    chk("t4_buf_pc", pc_o, BASE);
    flush_i = 1'b1; flush_pc_i = 32'h1c000100;
    tick();
    flush_i = 1'b0;
    chk("t4_flush_valid", 32'(inst_valid_o), 32'd0);
    chk("t4_flush_pc",    pc_o,   32'd0);
    chk("t4_flush_inst",  inst_o, 32'd0);
    chk("t4_drain_req",   32'(rom_req_o), 32'd1);
    chk("t4_drain_addr",  rom_addr_o, BASE + 32'h8);
    tick();
    chk("t4_drain_hold", rom_addr_o, BASE + 32'h8);
    rom_ack_i = 1'b1;
    tick();
    rom_ack_i = 1'b0;
    chk("t4_redirect_req",  32'(rom_req_o), 32'd1);
    chk("t4_redirect_addr", rom_addr_o, 32'h1c000100);
    chk("t4_no_push",       32'(inst_valid_o), 32'd0);
    rom_ack_i = 1'b1;
    tick();
    chk("t4_new_pc",   pc_o,   32'h1c000100);
    chk("t4_new_inst", inst_o, dat(32'h1c000100));

    // 5: flush, ack and pop in the same cycle; low PC bits ignored
    inst_ready_i = 1'b1; flush_i = 1'b1; flush_pc_i = 32'h1c000203;
    tick();
    flush_i = 1'b0; inst_ready_i = 1'b0; rom_ack_i = 1'b0;
    chk("t5_valid", 32'(inst_valid_o), 32'd0);
    chk("t5_pc",    pc_o, 32'd0);
    chk("t5_req",   32'(rom_req_o), 32'd1);
    chk("t5_addr",  rom_addr_o, 32'h1c000200);
    tick();
    chk("t5_still_empty", 32'(inst_valid_o), 32'd0);

    // 6: address wrap, then reset mid-request
    flush_i = 1'b1; flush_pc_i = 32'hFFFFFFF8; rom_ack_i = 1'b1; inst_ready_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t6_addr0", rom_addr_o, 32'hFFFFFFF8);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_pc",   pc_o, wrap_pc[i]);
      chk("t6_addr", rom_addr_o, wrap_pc[i] + 32'd4);
    end
    rst = 1'b1; rom_ack_i = 1'b0;
    tick();
    chk("t6_rst_req",   32'(rom_req_o),    32'd0);
    chk("t6_rst_addr",  rom_addr_o,        BASE);
    chk("t6_rst_valid", 32'(inst_valid_o), 32'd0);
    chk("t6_rst_inst",  inst_o,            32'd0);
    chk("t6_rst_pc",    pc_o,              32'd0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
